// File: rtl/mul_pkg.sv
// mul_pkg: shared constants, state encoding and function codes for the
// shift-add multiplier sequencer and ALU decode.
package mul_pkg;
   localparam int WIDTH   = 32;
   localparam int CNT_W   = $clog2(WIDTH);
   localparam int MUL_LAT = WIDTH + 3;

   localparam logic [5:0] SIG_MM   = 6'b011001;
   localparam logic [5:0] SIG_OUT  = 6'b111111;
   localparam logic [5:0] SIG_IDLE = 6'b000000;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_OUT  = 2'd2,
      ST_CAP  = 2'd3
   } state_t;

   // Function code the multiplier sees while the sequencer sits in a state.
   function automatic logic [5:0] state_sig(input state_t s);
      return (s == ST_RUN) ? SIG_MM : (s == ST_OUT) ? SIG_OUT : SIG_IDLE;
   endfunction
endpackage

// File: rtl/mul_sign_fix.sv
// mul_sign_fix: conditional two's-complement negate, used both to take
// operand magnitudes and to restore the product sign.
module mul_sign_fix #(
   parameter int W = 32
) (
   input  logic [W-1:0] i_val,
   input  logic         i_neg,
   output logic [W-1:0] o_val
);
   assign o_val = i_neg ? -i_val : i_val;
endmodule

// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl: start/busy/done sequencer driving the 32-step shift-add
// multiplier (MM x WIDTH, OUT x 1) and capturing the signed/unsigned product.
module mul_seq_ctrl
   import mul_pkg::*;
(
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_start,
   input  logic               i_is_signed,
   input  logic [WIDTH-1:0]   i_op_a,
   input  logic [WIDTH-1:0]   i_op_b,
   output logic               o_busy,
   output logic               o_done,
   output logic [2*WIDTH-1:0] o_product,
   output logic [5:0]         o_mul_signal,
   output logic [WIDTH-1:0]   o_mul_a,
   output logic [WIDTH-1:0]   o_mul_b,
   output logic               o_mul_rst,
   input  logic [2*WIDTH-1:0] i_mul_result
);
   state_t               r_state, w_state_nxt;
   logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
   logic                 r_neg, w_neg_nxt;
   logic [WIDTH-1:0]     r_mul_a, r_mul_b, w_mul_a_nxt, w_mul_b_nxt;
   logic [2*WIDTH-1:0]   r_product, w_product_nxt;
   logic                 r_busy, r_done, w_done_nxt;
   logic [5:0]           r_sig;
   logic [WIDTH-1:0]     w_mag_a, w_mag_b;
   logic [2*WIDTH-1:0]   w_prod_fix;

   // -2^(WIDTH-1) negates to itself, which reads correctly as unsigned.
   mul_sign_fix #(.W(WIDTH)) u_fix_a (
      .i_val(i_op_a), .i_neg(i_is_signed & i_op_a[WIDTH-1]), .o_val(w_mag_a));
   mul_sign_fix #(.W(WIDTH)) u_fix_b (
      .i_val(i_op_b), .i_neg(i_is_signed & i_op_b[WIDTH-1]), .o_val(w_mag_b));
   mul_sign_fix #(.W(2*WIDTH)) u_fix_p (
      .i_val(i_mul_result), .i_neg(r_neg), .o_val(w_prod_fix));

   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_neg_nxt     = r_neg;
      w_mul_a_nxt   = r_mul_a;
      w_mul_b_nxt   = r_mul_b;
      w_product_nxt = r_product;
      w_done_nxt    = 1'b0;
      case (r_state)
         ST_IDLE: if (i_start) begin
            w_state_nxt = ST_RUN;
            w_cnt_nxt   = '0;
            w_mul_a_nxt = w_mag_a;
            w_mul_b_nxt = w_mag_b;
            w_neg_nxt   = i_is_signed & (i_op_a[WIDTH-1] ^ i_op_b[WIDTH-1]);
         end
         ST_RUN: begin
            w_cnt_nxt   = r_cnt + 1'b1;
            w_state_nxt = (r_cnt == CNT_W'(WIDTH - 1)) ? ST_OUT : ST_RUN;
         end
         ST_OUT: w_state_nxt = ST_CAP;
         ST_CAP: begin
            w_state_nxt   = ST_IDLE;
            w_product_nxt = w_prod_fix;
            w_done_nxt    = 1'b1;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         r_state   <= ST_IDLE;
         r_cnt     <= '0;
         r_neg     <= 1'b0;
         r_mul_a   <= '0;
         r_mul_b   <= '0;
         r_product <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_sig     <= SIG_IDLE;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_neg     <= w_neg_nxt;
         r_mul_a   <= w_mul_a_nxt;
         r_mul_b   <= w_mul_b_nxt;
         r_product <= w_product_nxt;
         r_busy    <= (w_state_nxt != ST_IDLE);
         r_done    <= w_done_nxt;
         r_sig     <= state_sig(w_state_nxt);
      end
   end

   assign o_busy       = r_busy;
   assign o_done       = r_done;
   assign o_product    = r_product;
   assign o_mul_signal = r_sig;
   assign o_mul_a      = r_mul_a;
   assign o_mul_b      = r_mul_b;
   assign o_mul_rst    = ~i_reset;
endmodule

// File: tb/tb_mul_seq_ctrl.sv
// tb_mul_seq_ctrl: directed checks of the multiply sequencer against a
// behavioural multiplier that latches a*b when it sees the OUT code.
module tb_mul_seq_ctrl;
   import mul_pkg::*;

   logic               clk = 1'b0;
   logic               reset = 1'b0;
   logic               start = 1'b0;
   logic               is_signed = 1'b0;
   logic [WIDTH-1:0]   op_a = '0, op_b = '0;
   logic               busy, done, mul_rst;
   logic [2*WIDTH-1:0] product, mul_result;
   logic [5:0]         mul_signal;
   logic [WIDTH-1:0]   mul_a, mul_b;

   int n_pass = 0;
   int n_tot  = 0;

   mul_seq_ctrl dut (
      .i_clk(clk), .i_reset(reset), .i_start(start), .i_is_signed(is_signed),
      .i_op_a(op_a), .i_op_b(op_b), .o_busy(busy), .o_done(done),
      .o_product(product), .o_mul_signal(mul_signal), .o_mul_a(mul_a),
      .o_mul_b(mul_b), .o_mul_rst(mul_rst), .i_mul_result(mul_result));

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mul_rst) mul_result <= '0;
      else if (mul_signal == SIG_OUT) mul_result <= {32'b0, mul_a} * {32'b0, mul_b};
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tot++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic run_op(input string tag, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_ma,
                         input logic [63:0] exp_p);
      int lat, mm;
      is_signed = sgn; op_a = a; op_b = b; start = 1'b1;
      tick();
      start = 1'b0;
      chk({tag, "_busy"}, 64'(busy), 64'd1);
      chk({tag, "_mul_a"}, 64'(mul_a), 64'(exp_ma));
      lat = 1;
      mm = (mul_signal == SIG_MM) ? 1 : 0;
      while (!done && lat < 100) begin
         tick();
         lat++;
         if (mul_signal == SIG_MM) mm++;
      end
      chk({tag, "_lat"}, 64'(lat), 64'(MUL_LAT));
      chk({tag, "_mm"}, 64'(mm), 64'd32);
      chk({tag, "_prod"}, product, exp_p);
      chk({tag, "_busy_done"}, 64'(busy), 64'd0);
      tick();
      chk({tag, "_done_pulse"}, 64'(done), 64'd0);
   endtask

   initial begin
      int lat, ndone, bad;
      tick();
      tick();
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_prod", product, 64'd0);
      chk("rst_sig", 64'(mul_signal), 64'(SIG_IDLE));
      chk("rst_mul_a", 64'(mul_a), 64'd0);
      chk("rst_mul_b", 64'(mul_b), 64'd0);
      chk("rst_mul_rst", 64'(mul_rst), 64'd1);
      reset = 1'b1;
      tick();
      chk("rel_mul_rst", 64'(mul_rst), 64'd0);

      run_op("u3x5", 1'b0, 32'd3, 32'd5, 32'd3, 64'h0000_0000_0000_000F);
      run_op("s-7x6", 1'b1, 32'hFFFF_FFF9, 32'd6, 32'd7, 64'hFFFF_FFFF_FFFF_FFD6);
      run_op("umax", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
      run_op("smin", 1'b1, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
      run_op("s0x-5", 1'b1, 32'd0, 32'hFFFF_FFFB, 32'd0, 64'd0);

      // start pulsed mid-run with other operands must be ignored
      is_signed = 1'b0; op_a = 32'd3; op_b = 32'd5; start = 1'b1;
      tick();
      start = 1'b0;
      repeat (5) tick();
      op_a = 32'd9; op_b = 32'd9; start = 1'b1;
      tick();
      start = 1'b0;
      chk("ign_mul_a", 64'(mul_a), 64'd3);
      lat = 7;
      while (!done && lat < 100) begin tick(); lat++; end
      chk("ign_lat", 64'(lat), 64'(MUL_LAT));
      chk("ign_prod", product, 64'd15);
      ndone = 0;
      repeat (40) begin tick(); if (done) ndone++; end
      chk("ign_no_extra_done", 64'(ndone), 64'd0);
      chk("ign_prod_hold", product, 64'd15);

      // reset mid-run at cnt==10
      is_signed = 1'b0; op_a = 32'd7; op_b = 32'd7; start = 1'b1;
      tick();
      start = 1'b0;
      repeat (10) tick();
      reset = 1'b0;
      tick();
      chk("mid_busy", 64'(busy), 64'd0);
      chk("mid_done", 64'(done), 64'd0);
      chk("mid_prod", product, 64'd0);
      chk("mid_sig", 64'(mul_signal), 64'(SIG_IDLE));
      chk("mid_mul_a", 64'(mul_a), 64'd0);
      chk("mid_mul_b", 64'(mul_b), 64'd0);
      chk("mid_mul_rst", 64'(mul_rst), 64'd1);
      reset = 1'b1;
      tick();
      run_op("u2x2", 1'b0, 32'd2, 32'd2, 32'd2, 64'd4);

      // start held high: back-to-back 1x1
      is_signed = 1'b0; op_a = 32'd1; op_b = 32'd1; start = 1'b1;
      tick();
      lat = 1; bad = 0;
      for (int r = 0; r < 3; r++) begin
         while (!done && lat < 100) begin
            if (!busy) bad++;
            tick();
            lat++;
         end
         chk("b2b_lat", 64'(lat), 64'(MUL_LAT));
         chk("b2b_prod", product, 64'd1);
         chk("b2b_busy_low", 64'(busy), 64'd0);
         tick();
         lat = 1;
      end
      chk("b2b_busy_high", 64'(bad), 64'd0);
      start = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule

// File: doc/mul_seq_ctrl.md
# mul_seq_ctrl

Sequencer for the 32-step shift-add multiplier in the ALU. Accepts a multiply request with a start/busy/done handshake, drives the multiplier's 6-bit function code (MM for exactly WIDTH cycles, then OUT for one cycle), and captures the 64-bit product. Supports unsigned and signed operands: it feeds magnitudes to the unsigned multiplier and fixes the product sign on capture.

## Interface
- WIDTH, 32, operand width; product is 2*WIDTH
- SIG_MM, 6'b011001, multiplier step code
- SIG_OUT, 6'b111111, multiplier output-latch code
- SIG_IDLE, 6'b000000, code driven when not sequencing
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-low reset
- start  in  1  request; sampled only in IDLE
- is_signed  in  1  operands are two's complement when 1; sampled with start
- op_a  in  WIDTH  multiplicand; sampled with start
- op_b  in  WIDTH  multiplier; sampled with start
- busy  out  1  high from accept edge until the capture edge
- done  out  1  one-cycle pulse, product valid
- product  out  2*WIDTH  last result; held until the next capture
- mul_signal  out  6  function code to multiplier
- mul_a, mul_b  out  WIDTH  operand magnitudes to multiplier, stable for the whole operation
- mul_rst  out  1  active-high clear to multiplier, high while reset is low
- mul_result  in  2*WIDTH  multiplier output

## Operation
- States: IDLE, RUN, OUT, CAP.
- IDLE: mul_signal=SIG_IDLE. When start=1, latch magnitudes into mul_a/mul_b.
  - Unsigned: magnitude = operand.
  - Signed: magnitude = negative ? -operand : operand. -2^(WIDTH-1) maps to 2^(WIDTH-1) as unsigned.
  - Latch neg_flag = is_signed & (a_msb ^ b_msb).
  - Clear cnt; go to RUN.
- RUN: mul_signal=SIG_MM. cnt increments each edge. At the edge where cnt==WIDTH-1, go to OUT.
- OUT: mul_signal=SIG_OUT for exactly one cycle; go to CAP.
- CAP: on the next edge, product <= neg_flag ? -mul_result : mul_result. Pulse done; go to IDLE.
- start outside IDLE: ignored; no queuing.
- start in the cycle done is high: accepted, because the state is already IDLE.
- Zero operand: no special case. Full sequence runs; product = 0 (the negative-zero fixup still yields 0).
- Reset low at any edge (including mid-RUN): state=IDLE, cnt=0, busy=0, done=0, product=0, mul_a=mul_b=0, mul_signal=SIG_IDLE, mul_rst=1. The in-flight operation is discarded.

## Timing
- Reset values: busy 0, done 0, product 0, mul_signal SIG_IDLE, mul_a/mul_b 0, mul_rst 1 (0 once reset is high).
- Edge E0 accepts start. mul_signal=SIG_MM during the cycles following E0 through E32 (WIDTH edges, E1..E32, each a multiplier step).
- SIG_OUT follows E32. The multiplier latches its output at E33.
- Controller captures at E34. done is high in the cycle after E34.
- Latency: start-accept edge to done = WIDTH+3 cycles. Back-to-back throughput is one result per WIDTH+3 cycles.
- busy: rises after E0, falls after E34, coincident with done rising.
- mul_signal changes only at clock edges (registered), glitch-free. The multiplier's operand load happens on the transition into SIG_MM.

## Structure
- Shared package mul_pkg holds:
  - state encoding (IDLE/RUN/OUT/CAP)
  - SIG_MM, SIG_OUT, SIG_IDLE codes, reused by the Multiplier and ALU decode
  - MUL_LAT = WIDTH+3 for bench and scheduler use
- One natural sub-module, mul_sign_fix: combinational two's-complement magnitude/negate, parameterised on width. Instantiated twice at WIDTH for operands and once at 2*WIDTH for the product.
- Counter width: $clog2(WIDTH).

## Test plan
- Unsigned 3 × 5, is_signed=0 → product 64'h0000_0000_0000_000F. done exactly 35 cycles after the accept edge. mul_signal=SIG_MM for exactly 32 cycles.
- Signed -7 × 6 (op_a=32'hFFFF_FFF9) → mul_a=7, product 64'hFFFF_FFFF_FFFF_FFD6.
- Unsigned 32'hFFFF_FFFF × 32'hFFFF_FFFF → 64'hFFFF_FFFE_0000_0001. Signed 32'h8000_0000 × 32'h8000_0000 → 64'h4000_0000_0000_0000.
- start pulsed during RUN with different operands → ignored; first result unchanged; no extra done.
- reset low for one edge at cnt=10 → all outputs at reset values next cycle. A new 2 × 2 request afterwards → product 4 after 35 cycles.
- start held high continuously with operands 1 × 1 → done every 35 cycles. product stays 1; busy low only in the done cycle.
